// File: rtl/fpu_result_return.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_result_return
//  Description : Steers shared-FPU writeback results to the issuing thread's
//                FP register file through per-thread result FIFOs.
//  Revision    : 1.0 - initial release
// ============================================================================
module fpu_result_return #(
    parameter int DEPTH = 2,
    parameter int PW    = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          e,
    input  logic          issue_v,
    input  logic          issue_t,
    input  logic          wr_v,
    input  logic [4:0]    wn,
    input  logic [31:0]   wd,
    input  logic          rdy0,
    input  logic          rdy1,
    output logic          ww0,
    output logic [4:0]    wn0,
    output logic [31:0]   wd0,
    output logic          ww1,
    output logic [4:0]    wn1,
    output logic [31:0]   wd1,
    output logic          fpu_hold,
    output logic [PW-1:0] pend0,
    output logic [PW-1:0] pend1,
    output logic          ovf
);

    localparam int          c_AW   = $clog2(DEPTH);
    localparam int          c_CW   = c_AW + 1;
    localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_HOLD = c_CW'(DEPTH - 1);

    // Tag pipeline: index 0 is E1, index 3 is W.
    logic [3:0] r_tag_v;
    logic [3:0] r_tag_t;
    logic       r_ovf;

    logic [1:0]            w_rdy;
    logic [1:0]            w_ww;
    logic [1:0]            w_pop;
    logic [1:0]            w_push;
    logic [1:0]            w_drop;
    logic [1:0]            w_issue;
    logic [1:0]            w_hold;
    logic [1:0][36:0]      w_head;
    logic [1:0][PW-1:0]    w_pend;

    assign w_rdy = {rdy1, rdy0};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_tag_v <= '0;
            r_tag_t <= '0;
        end else if (e) begin
            r_tag_v <= {r_tag_v[2:0], issue_v};
            r_tag_t <= {r_tag_t[2:0], issue_t};
        end
    end

    for (genvar k = 0; k < 2; k++) begin : g_thread
        logic [36:0]     r_mem [DEPTH];
        logic [c_AW-1:0] r_rd;
        logic [c_AW-1:0] r_wr;
        logic [c_CW-1:0] r_cnt;
        logic [PW-1:0]   r_pend;
        logic            w_full;
        logic            w_accept;

        assign w_full     = (r_cnt == c_FULL);
        assign w_ww[k]    = (r_cnt != '0);
        assign w_pop[k]   = w_ww[k] & w_rdy[k];
        assign w_push[k]  = wr_v & r_tag_v[3] & (r_tag_t[3] == 1'(k));
        // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
        assign w_accept   = w_push[k] & (~w_full | w_pop[k]);
        assign w_drop[k]  = w_push[k] & w_full & ~w_pop[k];
        assign w_issue[k] = e & issue_v & (issue_t == 1'(k));
        assign w_hold[k]  = (r_cnt >= c_HOLD);
        assign w_head[k]  = w_ww[k] ? r_mem[r_rd] : '0;
        assign w_pend[k]  = r_pend;

        always_ff @(posedge clock) begin
            if (w_accept) begin
                r_mem[r_wr] <= {wn, wd};
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                r_rd   <= '0;
                r_wr   <= '0;
                r_cnt  <= '0;
                r_pend <= '0;
            end else begin
                if (w_pop[k]) begin
                    r_rd <= r_rd + 1'b1;
                end
                if (w_accept) begin
                    r_wr <= r_wr + 1'b1;
                end
                if (w_accept & ~w_pop[k]) begin
                    r_cnt <= r_cnt + 1'b1;
                end else if (w_pop[k] & ~w_accept) begin
                    r_cnt <= r_cnt - 1'b1;
                end
                if (w_issue[k] & ~w_pop[k] & (r_pend != '1)) begin
                    r_pend <= r_pend + 1'b1;
                end else if (w_pop[k] & ~w_issue[k] & (r_pend != '0)) begin
                    r_pend <= r_pend - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if ((wr_v & ~r_tag_v[3]) | (|w_drop)) begin
            r_ovf <= 1'b1;
        end
    end

    assign ww0      = w_ww[0];
    assign wn0      = w_head[0][36:32];
    assign wd0      = w_head[0][31:0];
    assign ww1      = w_ww[1];
    assign wn1      = w_head[1][36:32];
    assign wd1      = w_head[1][31:0];
    assign fpu_hold = |w_hold;
    assign pend0    = w_pend[0];
    assign pend1    = w_pend[1];
    assign ovf      = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_fpu_result_return.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fpu_result_return
//  Description : Self-checking bench for fpu_result_return with a queue-based
//                reference model of the per-thread result return path.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_result_return;

    localparam int DEPTH = 2;
    localparam int PW    = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          e = 1'b0, issue_v = 1'b0, issue_t = 1'b0, wr_v = 1'b0;
    logic [4:0]    wn = '0;
    logic [31:0]   wd = '0;
    logic          rdy0 = 1'b0, rdy1 = 1'b0;
    logic          ww0, ww1, fpu_hold, ovf;
    logic [4:0]    wn0, wn1;
    logic [31:0]   wd0, wd1;
    logic [PW-1:0] pend0, pend1;

    fpu_result_return #(.DEPTH(DEPTH), .PW(PW)) dut (
        .clock(clock), .reset(reset), .e(e), .issue_v(issue_v), .issue_t(issue_t),
        .wr_v(wr_v), .wn(wn), .wd(wd), .rdy0(rdy0), .rdy1(rdy1),
        .ww0(ww0), .wn0(wn0), .wd0(wd0), .ww1(ww1), .wn1(wn1), .wd1(wd1),
        .fpu_hold(fpu_hold), .pend0(pend0), .pend1(pend1), .ovf(ovf)
    );

    always #5 clock = ~clock;

    // Reference model: op tags in flight (index 3 = W), per-thread result queues.
    bit          mv[4];
    bit          mt[4];
    bit          mdone;
    logic [36:0] q0[$];
    logic [36:0] q1[$];
    int          mp0, mp1;
    bit          movf;
    logic [31:0] rx0[$];
    logic [31:0] rx1[$];

    int          n_pass = 0;
    int          n_total = 0;
    bit          g_force = 1'b0;
    logic [4:0]  g_wn = '0;
    logic [31:0] g_wd = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [36:0] h0, h1;
        h0 = (q0.size() != 0) ? q0[0] : 37'd0;
        h1 = (q1.size() != 0) ? q1[0] : 37'd0;
        chk("ww0",   32'(ww0),   32'(q0.size() != 0));
        chk("wn0",   32'(wn0),   32'(h0[36:32]));
        chk("wd0",   wd0,        h0[31:0]);
        chk("ww1",   32'(ww1),   32'(q1.size() != 0));
        chk("wn1",   32'(wn1),   32'(h1[36:32]));
        chk("wd1",   wd1,        h1[31:0]);
        chk("hold",  32'(fpu_hold),
            32'((q0.size() >= DEPTH - 1) || (q1.size() >= DEPTH - 1)));
        chk("pend0", 32'(pend0), 32'(mp0));
        chk("pend1", 32'(pend1), 32'(mp1));
        chk("ovf",   32'(ovf),   32'(movf));
    endtask

    task automatic tick();
        bit pop0, pop1;
        if (!reset && ww0 && rdy0) rx0.push_back(wd0);
        if (!reset && ww1 && rdy1) rx1.push_back(wd1);
        if (reset) begin
            foreach (mv[i]) begin mv[i] = 1'b0; mt[i] = 1'b0; end
            mdone = 1'b0; q0.delete(); q1.delete();
            mp0 = 0; mp1 = 0; movf = 1'b0;
        end else begin
            pop0 = (q0.size() != 0) && rdy0;
            pop1 = (q1.size() != 0) && rdy1;
            if (pop0) begin void'(q0.pop_front()); mp0--; end
            if (pop1) begin void'(q1.pop_front()); mp1--; end
            if (e && issue_v) begin
                if (issue_t) mp1++; else mp0++;
            end
            if (wr_v) begin
                if (!mv[3]) movf = 1'b1;
                else if (!mt[3]) begin
                    if (q0.size() < DEPTH) q0.push_back({wn, wd}); else movf = 1'b1;
                end else begin
                    if (q1.size() < DEPTH) q1.push_back({wn, wd}); else movf = 1'b1;
                end
            end
            if (e) begin
                for (int i = 3; i > 0; i--) begin mv[i] = mv[i-1]; mt[i] = mt[i-1]; end
                mv[0] = issue_v; mt[0] = issue_t; mdone = 1'b0;
            end else if (wr_v) begin
                mdone = 1'b1;
            end
        end
        @(posedge clock);
        #1;
        check_all();
    endtask

    // The W-stage result is returned as soon as its tag reaches W.
    task automatic drive(input bit ie, input bit iiv, input bit iit, input bit ir0, input bit ir1);
        e = ie; issue_v = iiv; issue_t = iit; rdy0 = ir0; rdy1 = ir1;
        wr_v = g_force || (mv[3] && !mdone && !reset);
        wn = g_wn; wd = g_wd;
        tick();
        if (wr_v) begin g_wn++; g_wd++; end
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        chk("rst_ww0", 32'(ww0), 0);
        chk("rst_hold", 32'(fpu_hold), 0);
        reset = 1'b0;

        // Single thread-0 op
        g_wn = 5'd3; g_wd = 32'h3F80_0000;
        drive(1, 1, 0, 1, 1);
        chk("t1_pend0_up", 32'(pend0), 1);
        drive(1, 0, 0, 1, 1);
        drive(1, 0, 0, 1, 1);
        drive(1, 0, 0, 1, 1);
        drive(1, 0, 0, 1, 1);
        chk("t1_ww0", 32'(ww0), 1);
        chk("t1_wn0", 32'(wn0), 3);
        chk("t1_wd0", wd0, 32'h3F80_0000);
        drive(1, 0, 0, 1, 1);
        chk("t1_ww0_off", 32'(ww0), 0);
        chk("t1_pend0_dn", 32'(pend0), 0);
        chk("t1_ww1", 32'(ww1), 0);

        // Alternating threads
        rx0.delete(); rx1.delete(); g_wd = 32'hA;
        drive(1, 1, 0, 1, 1); drive(1, 1, 1, 1, 1);
        drive(1, 1, 0, 1, 1); drive(1, 1, 1, 1, 1);
        for (int i = 0; i < 7; i++) drive(1, 0, 0, 1, 1);
        chk("t2_n0", rx0.size(), 2);
        chk("t2_n1", rx1.size(), 2);
        chk("t2_r0a", (rx0.size() > 0) ? rx0[0] : '1, 32'hA);
        chk("t2_r0b", (rx0.size() > 1) ? rx0[1] : '1, 32'hC);
        chk("t2_r1a", (rx1.size() > 0) ? rx1[0] : '1, 32'hB);
        chk("t2_r1b", (rx1.size() > 1) ? rx1[1] : '1, 32'hD);

        // Pipeline stall mid-stream
        rx0.delete(); rx1.delete(); g_wd = 32'h20;
        drive(1, 1, 0, 1, 1); drive(1, 1, 1, 1, 1);
        drive(0, 1, 0, 1, 1); drive(0, 1, 1, 1, 1); drive(0, 0, 0, 1, 1);
        drive(1, 1, 1, 1, 1); drive(1, 1, 0, 1, 1);
        for (int i = 0; i < 7; i++) drive(1, 0, 0, 1, 1);
        chk("t3_n0", rx0.size(), 2);
        chk("t3_n1", rx1.size(), 2);
        chk("t3_r0a", (rx0.size() > 0) ? rx0[0] : '1, 32'h20);
        chk("t3_r0b", (rx0.size() > 1) ? rx0[1] : '1, 32'h23);
        chk("t3_r1a", (rx1.size() > 0) ? rx1[0] : '1, 32'h21);
        chk("t3_r1b", (rx1.size() > 1) ? rx1[1] : '1, 32'h22);

        // Thread-1 backpressure and overflow
        rx0.delete(); rx1.delete(); g_wd = 32'h30; g_wn = 5'd16;
        drive(1, 1, 1, 1, 0); drive(1, 1, 1, 1, 0);
        for (int i = 0; i < 10 && q1.size() < 1; i++) drive(1, 0, 0, 1, 0);
        chk("t4_hold1", 32'(fpu_hold), 1);
        for (int i = 0; i < 10 && q1.size() < 2; i++) drive(1, 0, 0, 1, 0);
        chk("t4_full_ww1", 32'(ww1), 1);
        chk("t4_full_ovf", 32'(ovf), 0);
        drive(1, 1, 1, 1, 0);
        for (int i = 0; i < 10 && !movf; i++) drive(1, 0, 0, 1, 0);
        chk("t4_ovf", 32'(ovf), 1);
        chk("t4_head_wd", wd1, 32'h30);
        chk("t4_head_wn", 32'(wn1), 16);
        for (int i = 0; i < 6; i++) drive(1, 0, 0, 1, 1);
        chk("t4_ovf_sticky", 32'(ovf), 1);
        chk("t4_hold_off", 32'(fpu_hold), 0);
        chk("t4_n1", rx1.size(), 2);
        chk("t4_r1a", (rx1.size() > 0) ? rx1[0] : '1, 32'h30);
        chk("t4_r1b", (rx1.size() > 1) ? rx1[1] : '1, 32'h31);

        // Reset with ops in flight and a buffered result
        g_wd = 32'h40;
        drive(1, 1, 0, 0, 0);
        for (int i = 0; i < 10 && q0.size() < 1; i++) drive(1, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0); drive(1, 1, 1, 0, 0);
        reset = 1'b1;
        drive(1, 0, 0, 1, 1);
        reset = 1'b0;
        chk("t5_ww0", 32'(ww0), 0);
        chk("t5_ww1", 32'(ww1), 0);
        chk("t5_pend0", 32'(pend0), 0);
        chk("t5_pend1", 32'(pend1), 0);
        chk("t5_hold", 32'(fpu_hold), 0);
        chk("t5_ovf_clr", 32'(ovf), 0);
        g_force = 1'b1;
        drive(1, 0, 0, 1, 1);
        g_force = 1'b0;
        chk("t5_stale_ovf", 32'(ovf), 1);

        // Randomized traffic; the FPU honours fpu_hold
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        reset = 1'b0;
        for (int c = 0; c < 500; c++) begin
            bit hold_exp;
            reset    = ($urandom_range(0, 79) == 0);
            hold_exp = (q0.size() >= DEPTH - 1) || (q1.size() >= DEPTH - 1);
            g_wd     = $urandom;
            drive(hold_exp ? 1'b0 : 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fpu_result_return.md
Name: fpu_result_return

Overview:
- Return path of the shared FPU in the two-thread CPU: takes FPU writeback results and steers each one to the floating-point register file of the thread that issued it.
- Tracks the thread ID of every op through E1/E2/E3/W and buffers results per thread in a small FIFO.
- Backpressures the FPU when a thread's register-file write port cannot keep up.
- Reports per-thread outstanding FP ops so each IU can quiesce before a thread switch.

Parameters:
- DEPTH, 2: entries per thread result FIFO (power of 2, 2..8).
- PW, 4: width of pending counters; must hold 4+DEPTH.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- e  in  1  FPU pipeline advance enable; tag pipeline shifts only when 1.
- issue_v  in  1  an FP op enters E1 this cycle (meaningful only when e=1).
- issue_t  in  1  thread ID of issuing op (0/1).
- wr_v  in  1  FPU W stage presents a valid result this cycle; at most one pulse per op.
- wn  in  5  destination FP register of W result.
- wd  in  32  W result data.
- rdy0  in  1  thread-0 register file accepts a write this cycle.
- rdy1  in  1  thread-1 register file accepts a write this cycle.
- ww0  out  1  thread-0 write strobe (FIFO0 non-empty).
- wn0  out  5  thread-0 write register.
- wd0  out  32  thread-0 write data.
- ww1, wn1, wd1  out  1/5/32  same for thread 1.
- fpu_hold  out  1  request FPU stall.
- pend0  out  PW  thread-0 outstanding ops.
- pend1  out  PW  thread-1 outstanding ops.
- ovf  out  1  sticky error: push into a full FIFO.

Behaviour:
- Reset: all tag and valid regs, FIFO pointers and counts, pend0/pend1 and ovf cleared. Outputs after reset: ww0=ww1=0, wn*/wd*=0, fpu_hold=0, ovf=0.
- Reset asserted mid-operation discards all in-flight tags and buffered results; no write strobes are issued in the following cycle.
- Tag pipeline (valid,thread) stages e1,e2,e3,w:
  - On e=1: e1<=(issue_v,issue_t); e2<=e1; e3<=e2; w<=e3.
  - On e=0: all stages hold.
- Push on wr_v=1 into FIFO[w.thread], storing {wn,wd}.
- wr_v=1 while w.valid=0 is a protocol error: no push, ovf set.
- Pop: FIFOk pops when wwk & rdyk.
- Outputs wwk/wnk/wdk are driven from the FIFO head, registered storage; wnk/wdk read 0 when empty.
- Latency: a result pushed at edge N is visible on wwk after edge N, so a write can occur in cycle N+1.
- Push and pop on the same FIFO in the same cycle: count unchanged, allowed at any count, including full (the pop frees the slot first).
- Push when count==DEPTH and no pop: result dropped, ovf<=1 (sticky until reset).
- Pointers wrap modulo DEPTH.
- fpu_hold = (count0 >= DEPTH-1) | (count1 >= DEPTH-1), combinational from registered counts. This leaves one slot for the result already in W when the hold takes effect.
- pendk:
  - +1 on e & issue_v & issue_t==k.
  - -1 on pop of FIFOk.
  - Both in the same cycle: unchanged.
  - Never wraps; an underflow attempt is impossible by construction.
- Threads are independent: a full FIFO1 does not block pops from FIFO0. It does raise fpu_hold, because the FPU is shared.

Test Plan:
- Reset, then issue thread0 op (e=1 held), wr_v in W with wn=3, wd=0x3F800000, rdy0=1:
  - ww0=1, wn0=3, wd0=0x3F800000 one cycle after wr_v, for exactly 1 cycle.
  - pend0 goes 1 then 0; ww1 stays 0.
- Alternate issue_t 0,1,0,1 with e=1 and results 0xA..0xD:
  - thread0 receives 0xA, 0xC; thread1 receives 0xB, 0xD, in order.
- e=0 for 3 cycles mid-stream:
  - tags hold; results after resume are still steered to the correct threads.
- rdy1=0 with DEPTH=2 and two thread1 results:
  - fpu_hold=1 after the first push; count1=2 after the second; ovf=0.
  - With rdy1=1 the results drain in order and fpu_hold drops when count1 falls below 1.
- Third thread1 push with rdy1=0 while full:
  - ovf=1 and stays 1; the FIFO contents are unchanged.
- Assert reset with 2 ops in flight and 1 buffered:
  - next cycle all ww=0, pend=0, fpu_hold=0.
  - a later stale wr_v sets ovf.
